spi_controller: RTL
===================

# spi_controller

SPI Mode 0 controller that generates write frames for the on-chip `spi_peripheral` register file. It is used as a test and driver block, for example in loopback benches and on-chip configuration sequencers. A single request handshake hands it a 16-bit frame: bit 15 is R/W, bits 14:8 are the address and bits 7:0 are the data. It then drives `ncs`, `sclk` and `copi` MSB-first, with timing slow enough for the peripheral's 3-flop synchronizers.

## Interface
Parameters:
- `HALF_PERIOD`, default 4: clk cycles per SCLK half-period. Legal range 3..255.
- `CS_SETUP`, default 4: clk cycles from `ncs` falling to the first SCLK rising edge. Legal range 1..255.
- `CS_HOLD`, default 4: clk cycles from the last SCLK falling edge to `ncs` rising. Legal range 1..255.
- `CS_GAP`, default 8: minimum clk cycles `ncs` stays high before `done`. Legal range 4..255.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, so a request can be accepted.
- `req_write` in 1: frame bit 15 (1 = write).
- `req_addr` in 7: frame bits 14:8.
- `req_data` in 8: frame bits 7:0.
- `busy` out 1: a frame is in progress, from acceptance until `done`.
- `done` out 1: one-cycle pulse when the frame and its gap are complete.
- `ncs` out 1: chip select, active low.
- `sclk` out 1: serial clock, idle low.
- `copi` out 1: serial data, MSB first.

## Operation
- All outputs are registered.
- Reset values: `ncs`=1, `sclk`=0, `copi`=0, `busy`=0, `done`=0, `req_ready`=1.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
- Internal counters: an 8-bit phase counter and a 4-bit bit index that counts 15 down to 0.
- IDLE: `req_ready`=1.
  - If `req_valid` is high, capture the frame {req_write, req_addr, req_data} into a 16-bit shift register.
  - Drive `ncs`=0 and `copi`=frame[15], then go to SETUP.
  - Inputs are not sampled again until the next IDLE.
- SETUP: hold for `CS_SETUP` cycles with `sclk`=0, then go to SCK_HI.
- SCK_HI: `sclk`=1 for `HALF_PERIOD` cycles. The peripheral samples `copi` on this rising edge.
  - If bit index > 0, go to SCK_LO.
  - If bit index = 0, go to HOLD.
- SCK_LO: on entry, `sclk`=0 and `copi` advances to the next bit at the same edge. Hold `HALF_PERIOD` cycles, decrement the bit index, then go to SCK_HI.
- HOLD: `sclk`=0 and `copi` holds bit 0 for `CS_HOLD` cycles. Then `ncs`=1, `copi`=0, go to GAP.
- GAP: hold for `CS_GAP` cycles so the peripheral can commit the register. Then go to IDLE with `done`=1 for one cycle; `req_ready`=1 and `busy`=0 in that same cycle.
- `req_valid` while busy is ignored. There is no queueing and `req_ready` stays 0.
- `req_write`=0 frames are shifted out identically. The controller has no CIPO input.
- Reset mid-frame takes effect immediately:
  - `ncs` goes high and `sclk` goes low.
  - The frame is discarded and no `done` is issued.
  - The peripheral sees an aborted frame with fewer than 16 bits and must not commit it.

## Timing
- Cycle 0 is the acceptance edge (`req_valid` && `req_ready`). `ncs` is low from cycle 1.
- `ncs` low duration is exactly CS_SETUP + 31·HALF_PERIOD + CS_HOLD cycles. With defaults this is cycles 1..132.
- Exactly 16 SCLK rising edges occur per frame. The first is at cycle CS_SETUP+1 and they are spaced 2·HALF_PERIOD apart.
- `copi` is stable for the full HALF_PERIOD before and after every rising edge.
- `ncs` is high for CS_GAP cycles, then `done` pulses. With defaults, `done` is at cycle 141.
- A new request held high during the `done` cycle is accepted on that edge. Back-to-back frames therefore have a gap of exactly CS_GAP+1 cycles with `ncs` high.
- `busy` is 1 from cycle 1 through the cycle before `done`.

## Test plan
- Single write, default parameters: write=1, addr=0x00, data=0xF0.
  - `copi` sampled at the 16 `sclk` rising edges reads 0x80F0.
  - `ncs` is low for 132 cycles.
  - `done` pulses at cycle 141.
  - Exactly 16 `sclk` rising edges.
- Loopback with `spi_peripheral`: writes to 0x04 ← 0x80, 0x00 ← 0xA5, then 0x03 ← 0x3C.
  - After each `done`, pwm_duty_cycle=0x80, en_reg_out_7_0=0xA5 and en_reg_pwm_15_8=0x3C respectively.
  - No other register changes.
- Back-to-back: `req_valid` held high with two frames (0x8155, 0x82AA).
  - Second frame accepted on the first `done` cycle.
  - `ncs` high for exactly 9 cycles between frames.
  - Both frames' bits are correct.
- Busy/stability:
  - Pulse `req_valid` at cycle 50 with different addr/data: it is ignored.
  - Change `req_data` mid-frame: the shifted bits still match the captured value.
  - `req_ready` stays 0 until `done`.
- Reset mid-frame: assert `rst_n`=0 at cycle 60.
  - `ncs`=1, `sclk`=0, `copi`=0 immediately.
  - No `done`.
  - Peripheral registers are unchanged.
  - The next request after reset completes normally.
- HALF_PERIOD=3, CS_GAP=4: frame 0x8433.
  - `ncs` low for 4+93+4=101 cycles.
  - In loopback, pwm_duty_cycle=0x33.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode 0 write-frame generator: one 16-bit frame per request, MSB first,
// paced slowly enough for a peripheral that synchronizes sclk/copi/ncs.
module spi_controller #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int CS_GAP      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

  localparam logic [7:0] HP_M1    = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);

  state_t      state, state_d;
  logic [7:0]  phase, phase_d;
  logic [3:0]  bit_idx, bit_idx_d;
  logic [15:0] shreg, shreg_d;
  logic        ncs_d, sclk_d, copi_d, busy_d, done_d, ready_d;

  // phase is loaded with (duration-1) on state entry and the state exits at 0
  always_comb begin
    state_d   = state;
    phase_d   = (phase != 8'd0) ? phase - 8'd1 : phase;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    ncs_d     = ncs;
    sclk_d    = sclk;
    copi_d    = copi;
    busy_d    = busy;
    done_d    = 1'b0;
    ready_d   = req_ready;
    case (state)
      IDLE: begin
        phase_d = phase;
        if (req_valid) begin
          shreg_d   = {req_write, req_addr, req_data};
          copi_d    = req_write;
          ncs_d     = 1'b0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          bit_idx_d = 4'd15;
          phase_d   = SETUP_M1;
          state_d   = SETUP;
        end
      end
      SETUP: if (phase == 8'd0) begin
        sclk_d  = 1'b1;
        phase_d = HP_M1;
        state_d = SCK_HI;
      end
      SCK_HI: if (phase == 8'd0) begin
        sclk_d = 1'b0;
        if (bit_idx == 4'd0) begin
          phase_d = HOLD_M1;
          state_d = HOLD;
        end else begin
          // data changes on the falling edge, a full half-period before the next rise
          shreg_d = {shreg[14:0], 1'b0};
          copi_d  = shreg[14];
          phase_d = HP_M1;
          state_d = SCK_LO;
        end
      end
      SCK_LO: if (phase == 8'd0) begin
        bit_idx_d = bit_idx - 4'd1;
        sclk_d    = 1'b1;
        phase_d   = HP_M1;
        state_d   = SCK_HI;
      end
      HOLD: if (phase == 8'd0) begin
        ncs_d   = 1'b1;
        copi_d  = 1'b0;
        phase_d = GAP_M1;
        state_d = GAP;
      end
      GAP: if (phase == 8'd0) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 8'd0;
      bit_idx   <= 4'd0;
      shreg     <= 16'd0;
      ncs       <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      ncs       <= ncs_d;
      sclk      <= sclk_d;
      copi      <= copi_d;
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= ready_d;
    end
  end

endmodule
